qif_neuron_array: RTL and testbench
===================================

QIF_NEURON_ARRAY -- requirements
Module: qif_neuron_array

Interface
REQ-001 The block SHALL expose parameter N_CH, default 4, as the number of neuron channels (1..16).
REQ-002 The block SHALL expose parameter W, default 8, as the signed width of membrane voltage and input current.
REQ-003 The block SHALL expose parameter SHIFT_B, default 2, as the arithmetic right shift applied to input B (gain 1/4).
REQ-004 The block SHALL expose parameter SHIFT_SQ, default 4, as the right shift applied to V*V (gain 1/16).
REQ-005 The block SHALL expose parameter REFRAC, default 2, as the refractory length in accepted updates (0..15).
REQ-006 The block SHALL expose parameter V_INIT, default -20, as the per-channel voltage after reset.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-008 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 The block SHALL have port in_valid, input, 1 bit: an update request is present.
REQ-010 The block SHALL have port in_ready, output, 1 bit: the block accepts the request this cycle.
REQ-011 The block SHALL have port in_ch, input, clog2(N_CH) bits (minimum 1): target channel.
REQ-012 The block SHALL have port in_b, input, W bits signed: input current B.
REQ-013 The block SHALL have ports cfg_vpeak and cfg_vreset, input, W bits signed each: spike threshold and reset voltage.
REQ-014 The block SHALL have port out_valid, output, 1 bit, and port out_ready, input, 1 bit: result handshake.
REQ-015 The block SHALL have outputs out_ch (in_ch width), out_v (W bits signed) and out_spike (1 bit), describing the result.

Function
REQ-016 The block SHALL keep per-channel state: voltage V[c] (W bits signed) and refractory counter R[c] (4 bits).
REQ-017 A transfer SHALL occur when in_valid and in_ready are both high at a rising clk edge; in_ready SHALL equal (!out_valid || out_ready).
REQ-018 Each transfer SHALL produce exactly one result, registered, with out_valid high on the next cycle (latency 1); out_ch/out_v/out_spike SHALL be held stable while out_valid && !out_ready.
REQ-019 The refractory path SHALL apply when R[c] != 0: V[c] := cfg_vreset, R[c] := R[c]-1, out_spike = 0, and in_b SHALL be ignored.
REQ-020 The integration path SHALL apply when R[c] == 0: Vn = V + (B >>> SHIFT_B) + ((V*V) >> SHIFT_SQ), computed at 2W+2 bits signed and saturated to [-2^(W-1), 2^(W-1)-1].
REQ-021 On the integration path, if saturated Vn >= cfg_vpeak (signed compare), the block SHALL set V[c] := cfg_vreset, R[c] := REFRAC and out_spike = 1; otherwise it SHALL set V[c] := Vn and out_spike = 0.
REQ-022 out_v SHALL equal the value written to V[c] by that transfer; out_ch SHALL equal the in_ch of that transfer.
REQ-023 Channels not addressed by a transfer SHALL hold V and R unchanged.
REQ-024 A transfer with in_ch >= N_CH SHALL be accepted, SHALL change no state and SHALL produce no result.
REQ-025 cfg_vpeak and cfg_vreset SHALL be sampled at the transfer edge; changes between transfers SHALL take effect on the next transfer only.
REQ-026 Back-to-back transfers to the same channel SHALL use the voltage written by the previous transfer (no hazard).

Reset
REQ-027 While rst_n is low, the block SHALL asynchronously set every V[c] := V_INIT, every R[c] := 0, out_valid := 0, out_spike := 0, out_v := 0 and out_ch := 0.
REQ-028 A transfer coincident with reset assertion SHALL be discarded; after rst_n deasserts, the first rising edge SHALL be able to accept a transfer.

Verification
REQ-029 Reset then ch0 B=40 three times -> out_v 15 (spike 0), 39 (spike 0), then Vn saturates to 127 >= 50 -> out_v -20, out_spike 1.
REQ-030 After the spike in REQ-029, two ch0 transfers with B=100 -> out_v -20, spike 0 both times (refractory); third -> out_v 15.
REQ-031 Reset, ch1 B=-128 -> out_v -27 (-20-32+25); ch0 and ch2/ch3 state unchanged (checked by subsequent B=0 reads: out_v 5 each, i.e. -20+25).
REQ-032 Hold out_ready=0 with out_valid=1 -> in_ready 0, outputs stable for 5 cycles, no state change; release -> next transfer accepted.
REQ-033 Set cfg_vpeak=10 between transfers; ch0 from 15 with B=0 -> spike 1, out_v = cfg_vreset.
REQ-034 Assert rst_n low mid-stream with out_valid=1 -> out_valid 0 immediately (asynchronously); all channels return V_INIT.

Source files
------------

// File: rtl/qif_neuron_array.sv
// qif_neuron_array: time-multiplexed quadratic integrate-and-fire neurons.
// One update request per transfer; each transfer updates a single channel's
// membrane voltage / refractory counter and returns a registered result
// through a valid/ready output stage with a one-cycle latency.
module qif_neuron_array #(
    parameter int N_CH     = 4,
    parameter int W        = 8,
    parameter int SHIFT_B  = 2,
    parameter int SHIFT_SQ = 4,
    parameter int REFRAC   = 2,
    parameter int V_INIT   = -20,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CH_W-1:0]     in_ch,
    input  logic signed [W-1:0] in_b,
    input  logic signed [W-1:0] cfg_vpeak,
    input  logic signed [W-1:0] cfg_vreset,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CH_W-1:0]     out_ch,
    output logic signed [W-1:0] out_v,
    output logic                out_spike
);

    // Wide enough that V + B/4 + V*V/16 can never overflow before saturation.
    localparam int WX = 2 * W + 2;
    localparam logic signed [WX-1:0] SAT_MAX = {{(W + 3){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [WX-1:0] SAT_MIN = {{(W + 3){1'b1}}, {(W - 1){1'b0}}};
    localparam logic signed [W-1:0]  V_RST   = W'(V_INIT);
    localparam logic [3:0]           R_LOAD  = 4'(REFRAC);

    // Per-channel neuron state.
    logic signed [W-1:0] v_q [N_CH];
    logic signed [W-1:0] v_d [N_CH];
    logic [3:0]          r_q [N_CH];
    logic [3:0]          r_d [N_CH];

    // Registered result stage.
    logic                out_valid_q, out_valid_d;
    logic [CH_W-1:0]     out_ch_q, out_ch_d;
    logic signed [W-1:0] out_v_q, out_v_d;
    logic                out_spike_q, out_spike_d;

    // Datapath intermediates.
    logic                ch_ok;
    logic [CH_W-1:0]     ch_idx;
    logic signed [W-1:0] v_cur;
    logic [3:0]          r_cur;
    logic signed [WX-1:0] v_ext;
    logic signed [WX-1:0] b_ext;
    logic signed [WX-1:0] b_sh;
    logic signed [WX-1:0] sq;
    logic signed [WX-1:0] sq_sh;
    logic signed [WX-1:0] sum;
    logic signed [W-1:0]  v_sat;
    logic                 spike_hit;
    logic                 fire;

    assign in_ready  = !out_valid_q || out_ready;
    assign fire      = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_v     = out_v_q;
    assign out_spike = out_spike_q;

    // Integration arithmetic for the addressed channel, saturated to W bits.
    always_comb begin
        ch_ok  = (32'(in_ch) < N_CH);
        ch_idx = ch_ok ? in_ch : '0;
        v_cur  = v_q[ch_idx];
        r_cur  = r_q[ch_idx];
        v_ext  = {{(WX - W){v_cur[W-1]}}, v_cur};
        b_ext  = {{(WX - W){in_b[W-1]}}, in_b};
        b_sh   = b_ext >>> SHIFT_B;
        sq     = v_ext * v_ext;
        sq_sh  = sq >>> SHIFT_SQ;
        sum    = v_ext + b_sh + sq_sh;
        if (sum > SAT_MAX) begin
            v_sat = SAT_MAX[W-1:0];
        end else if (sum < SAT_MIN) begin
            v_sat = SAT_MIN[W-1:0];
        end else begin
            v_sat = sum[W-1:0];
        end
        spike_hit = (v_sat >= cfg_vpeak);
    end

    // Next-state selection: refractory hold, spike/reset, or plain integrate.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            v_d[i] = v_q[i];
            r_d[i] = r_q[i];
        end
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        out_v_d     = out_v_q;
        out_spike_d = out_spike_q;

        if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (fire && ch_ok) begin
            out_valid_d = 1'b1;
            out_ch_d    = in_ch;
            if (r_cur != 4'd0) begin
                v_d[ch_idx] = cfg_vreset;
                r_d[ch_idx] = r_cur - 4'd1;
                out_v_d     = cfg_vreset;
                out_spike_d = 1'b0;
            end else if (spike_hit) begin
                v_d[ch_idx] = cfg_vreset;
                r_d[ch_idx] = R_LOAD;
                out_v_d     = cfg_vreset;
                out_spike_d = 1'b1;
            end else begin
                v_d[ch_idx] = v_sat;
                out_v_d     = v_sat;
                out_spike_d = 1'b0;
            end
        end
    end

    // State and result registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                v_q[i] <= V_RST;
                r_q[i] <= 4'd0;
            end
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_v_q     <= '0;
            out_spike_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                v_q[i] <= v_d[i];
                r_q[i] <= r_d[i];
            end
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_v_q     <= out_v_d;
            out_spike_q <= out_spike_d;
        end
    end

endmodule

// File: tb/tb_qif_neuron_array.sv
// tb_qif_neuron_array: scoreboard bench for qif_neuron_array.
// Driver issues transfers and pushes model results; monitor pops and compares.
module tb_qif_neuron_array;

    localparam int N_CH   = 4;
    localparam int REFRAC = 2;
    localparam int V_INIT = -20;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        in_ch = 2'd0;
    logic signed [7:0] in_b = 8'sd0;
    logic signed [7:0] cfg_vpeak = 8'sd50;
    logic signed [7:0] cfg_vreset = -8'sd20;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [1:0]        out_ch;
    logic signed [7:0] out_v;
    logic              out_spike;

    typedef struct {
        int ch;
        int v;
        bit spike;
    } exp_t;

    exp_t scb[$];
    int   mV[N_CH];
    int   mR[N_CH];
    int   errCount = 0;
    int   chkCount = 0;
    bit   stallRand = 1'b0;

    qif_neuron_array dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ch      (in_ch),
        .in_b       (in_b),
        .cfg_vpeak  (cfg_vpeak),
        .cfg_vreset (cfg_vreset),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ch     (out_ch),
        .out_v      (out_v),
        .out_spike  (out_spike)
    );

    always #5 clk = ~clk;

    // Reference neuron population: all channels back to the power-on voltage.
    function automatic void modelReset();
        for (int i = 0; i < N_CH; i++) begin
            mV[i] = V_INIT;
            mR[i] = 0;
        end
    endfunction

    // Reference update rule in plain integer arithmetic.
    function automatic exp_t modelStep(int ch, int b, int vpeak, int vreset);
        exp_t e;
        int   vn;
        e.ch = ch;
        if (mR[ch] > 0) begin
            mR[ch] = mR[ch] - 1;
            mV[ch] = vreset;
            e.v = vreset;
            e.spike = 1'b0;
        end else begin
            vn = mV[ch] + (b >>> 2) + (mV[ch] * mV[ch]) / 16;
            if (vn > 127) vn = 127;
            if (vn < -128) vn = -128;
            if (vn >= vpeak) begin
                mV[ch] = vreset;
                mR[ch] = REFRAC;
                e.v = vreset;
                e.spike = 1'b1;
            end else begin
                mV[ch] = vn;
                e.v = vn;
                e.spike = 1'b0;
            end
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        chkCount++;
        if (act != exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one update and record the model's answer when it is accepted.
    task automatic applyStimulus(input int ch, input int b);
        int tries = 0;
        bit done = 1'b0;
        while (!done) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_ch     = ch[1:0];
            in_b      = b[7:0];
            out_ready = stallRand ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (in_ready) begin
                scb.push_back(modelStep(ch, b, int'(cfg_vpeak), int'(cfg_vreset)));
                done = 1'b1;
            end else begin
                tries++;
                if (tries > 100) begin
                    chkCount++;
                    errCount++;
                    $display("[TB] FAIL accept_timeout: in_ready stayed 0, expected 1");
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
    endtask

    task automatic pulseReset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        scb.delete();
        modelReset();
        @(negedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    // Monitor: check handshake and pop/compare each presented result.
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            checkOutput("in_ready", int'(in_ready), int'(!out_valid || out_ready));
            if (out_valid) begin
                chkCount++;
                if (scb.size() == 0) begin
                    errCount++;
                    $display("[TB] FAIL unexpected_result: ch=%0d v=%0d spike=%0d, expected no result",
                             out_ch, out_v, out_spike);
                end else begin
                    if (int'(out_ch) != scb[0].ch || int'(out_v) != scb[0].v
                        || out_spike != scb[0].spike) begin
                        errCount++;
                        $display("[TB] FAIL result: got ch=%0d v=%0d spike=%0d, expected ch=%0d v=%0d spike=%0d",
                                 out_ch, out_v, out_spike, scb[0].ch, scb[0].v, scb[0].spike);
                    end
                    if (out_ready) void'(scb.pop_front());
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios, random traffic, mid-stream reset and drain.
    initial begin
        int waitCycles;
        modelReset();
        #12;
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_out_v", int'(out_v), 0);
        checkOutput("reset_in_ready", int'(in_ready), 1);
        @(negedge clk);
        #3;
        rst_n = 1'b1;

        // Spike on third drive, then refractory, then recovery.
        for (int i = 0; i < 3; i++) applyStimulus(0, 40);
        applyStimulus(0, 100);
        applyStimulus(0, 100);
        applyStimulus(0, 40);
        idleCycles(2);

        // Strongly negative input on one channel leaves the others untouched.
        pulseReset();
        applyStimulus(1, -128);
        for (int c = 0; c < N_CH; c++) applyStimulus(c, 0);
        idleCycles(2);

        // Threshold lowered between transfers takes effect on the next one.
        pulseReset();
        applyStimulus(0, 40);
        @(negedge clk);
        cfg_vpeak = 8'sd10;
        applyStimulus(0, 0);
        @(negedge clk);
        cfg_vpeak = 8'sd50;
        idleCycles(2);

        // Back-pressure: result held, requests refused, nothing consumed.
        applyStimulus(2, 40);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_ch     = 2'd2;
            in_b      = 8'sd100;
            #1;
            checkOutput("stall_in_ready", int'(in_ready), 0);
        end
        #1;
        in_valid = 1'b0;
        applyStimulus(2, 0);
        applyStimulus(2, 0);
        idleCycles(2);

        // Randomised traffic with random back-pressure and config changes.
        stallRand = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk);
                cfg_vpeak  = 8'($urandom_range(20, 127));
                cfg_vreset = 8'(-int'($urandom_range(0, 40)));
            end
            applyStimulus(int'($urandom_range(0, N_CH - 1)), int'($urandom_range(0, 255)) - 128);
        end
        stallRand = 1'b0;

        // Asynchronous reset while a result is being held.
        cfg_vpeak  = 8'sd50;
        cfg_vreset = -8'sd20;
        applyStimulus(3, 60);
        @(negedge clk);
        out_ready = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_out_valid", int'(out_valid), 0);
        checkOutput("async_rst_out_v", int'(out_v), 0);
        checkOutput("async_rst_out_ch", int'(out_ch), 0);
        scb.delete();
        modelReset();
        @(negedge clk);
        out_ready = 1'b1;
        #3;
        rst_n = 1'b1;
        for (int c = 0; c < N_CH; c++) applyStimulus(c, 0);

        // Drain outstanding results.
        waitCycles = 0;
        while (scb.size() != 0 && waitCycles < 50) begin
            idleCycles(1);
            waitCycles++;
        end
        checkOutput("drain_pending", scb.size(), 0);
        idleCycles(2);
        checkOutput("final_out_valid", int'(out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errCount, chkCount);
        $finish;
    end

endmodule
